// File: rtl/rename_commit_scheduler_pkg.sv
// Shared types and defaults for the rename commit scheduler.
package rename_commit_scheduler_pkg;

  localparam int unsigned PhysRegNumWidth = 7;

  localparam int unsigned CommitWidthDefault = 2;

  typedef logic [PhysRegNumWidth-1:0] commit_entry_t;

endpackage

// File: rtl/rename_commit_scheduler_compactor.sv
// Packs the write-retiring lanes of a retire group into slots 0..count-1, oldest lane first.
module rename_commit_scheduler_compactor
  import rename_commit_scheduler_pkg::*;
#(
  parameter int unsigned CommitWidth = CommitWidthDefault,
  parameter int unsigned CntWidth    = $clog2(CommitWidth + 1)
) (
  input  logic [CommitWidth-1:0]                 valid_i,
  input  logic [CommitWidth-1:0]                 write_i,
  input  logic [CommitWidth*PhysRegNumWidth-1:0] id_i,
  output commit_entry_t                          ids_o [CommitWidth],
  output logic [CntWidth-1:0]                    count_o
);

  logic                sel [CommitWidth];
  logic [CntWidth-1:0] pos [CommitWidth];
  logic [CntWidth-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CommitWidth; i++) begin
      sel[i] = valid_i[i] & write_i[i];
      pos[i] = cnt;
      cnt    = cnt + CntWidth'(sel[i]);
    end
    count_o = cnt;
  end

  // Each output slot picks the selected lane whose prefix count equals the slot index.
  always_comb begin
    for (int j = 0; j < CommitWidth; j++) begin
      ids_o[j] = '0;
      for (int i = 0; i < CommitWidth; i++) begin
        if (sel[i] && pos[i] == CntWidth'(j)) begin
          ids_o[j] = id_i[i*PhysRegNumWidth +: PhysRegNumWidth];
        end
      end
    end
  end

endmodule

// File: rtl/rename_commit_scheduler.sv
// Buffers ROB write-commits in order and drains them one per cycle to the rename unit.
module rename_commit_scheduler
  import rename_commit_scheduler_pkg::*;
#(
  parameter int unsigned CommitWidth    = CommitWidthDefault,
  parameter int unsigned QueueDepthLog2 = 3,
  parameter int unsigned StatWidth      = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [CommitWidth-1:0]                 retire_valid_i,
  input  logic [CommitWidth-1:0]                 retire_with_write_i,
  input  logic [CommitWidth*PhysRegNumWidth-1:0] retire_wr_register_i,
  output logic                                   retire_ready_o,
  output logic                                   commit_valid_o,
  output logic                                   commit_with_write_o,
  output logic [PhysRegNumWidth-1:0]             commited_wr_register_o,
  input  logic                                   decode_regwrite_req_i,
  input  logic                                   rename_valid_i,
  output logic                                   regwrite_o,
  output logic                                   rename_stall_o,
  output logic                                   idle_o,
  output logic [StatWidth-1:0]                   freed_count_o,
  output logic [StatWidth-1:0]                   stall_count_o
);

  localparam int unsigned Depth    = 1 << QueueDepthLog2;
  localparam int unsigned OccWidth = QueueDepthLog2 + 1;
  localparam int unsigned CntWidth = $clog2(CommitWidth + 1);

  commit_entry_t               mem_q [Depth];
  logic [QueueDepthLog2-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OccWidth-1:0]         occ_q, occ_d, free_slots;
  logic                        commit_valid_q, commit_valid_d;
  commit_entry_t               commit_reg_q, commit_reg_d;
  logic [StatWidth-1:0]        freed_q, freed_d, stall_q, stall_d;

  commit_entry_t               cmp_ids [CommitWidth];
  logic [CntWidth-1:0]         cmp_cnt;
  logic [CntWidth-1:0]         n_enq;
  logic                        deq;

  rename_commit_scheduler_compactor #(
    .CommitWidth(CommitWidth),
    .CntWidth   (CntWidth)
  ) u_compactor (
    .valid_i(retire_valid_i),
    .write_i(retire_with_write_i),
    .id_i   (retire_wr_register_i),
    .ids_o  (cmp_ids),
    .count_o(cmp_cnt)
  );

  // Readiness looks only at registered occupancy so the ROB sees a stable handshake.
  assign free_slots     = OccWidth'(Depth) - occ_q;
  assign retire_ready_o = free_slots >= OccWidth'(CommitWidth);
  assign n_enq          = retire_ready_o ? cmp_cnt : '0;
  assign deq            = occ_q != '0;

  always_comb begin
    occ_d          = occ_q + OccWidth'(n_enq) - OccWidth'(deq);
    tail_d         = tail_q + QueueDepthLog2'(n_enq);
    head_d         = head_q;
    commit_valid_d = deq;
    commit_reg_d   = commit_reg_q;
    if (deq) begin
      head_d       = head_q + 1'b1;
      commit_reg_d = mem_q[head_q];
    end
    freed_d = freed_q;
    stall_d = stall_q;
    if (commit_valid_q && freed_q != '1) freed_d = freed_q + 1'b1;
    if (rename_stall_o && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q         <= '0;
      tail_q         <= '0;
      occ_q          <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q   <= '0;
      freed_q        <= '0;
      stall_q        <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      occ_q          <= occ_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q   <= commit_reg_d;
      freed_q        <= freed_d;
      stall_q        <= stall_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < CommitWidth; j++) begin
      if (CntWidth'(j) < n_enq) begin
        mem_q[tail_q + QueueDepthLog2'(j)] <= cmp_ids[j];
      end
    end
  end

  assign commit_valid_o         = commit_valid_q;
  assign commit_with_write_o    = commit_valid_q;
  assign commited_wr_register_o = commit_reg_q;
  assign idle_o                 = (occ_q == '0) & ~commit_valid_q;
  assign freed_count_o          = freed_q;
  assign stall_count_o          = stall_q;

  assign regwrite_o     = rst_ni & decode_regwrite_req_i & rename_valid_i;
  assign rename_stall_o = rst_ni & decode_regwrite_req_i & ~rename_valid_i;

endmodule
